// File: rtl/comm_pkg.sv
// Shared opcodes, acknowledge byte and FSM state encoding for the queued
// copter command master.
package comm_pkg;

  localparam logic [7:0] REQ_BATT  = 8'h01;
  localparam logic [7:0] SET_PTCH  = 8'h02;
  localparam logic [7:0] SET_ROLL  = 8'h03;
  localparam logic [7:0] SET_YAW   = 8'h04;
  localparam logic [7:0] SET_THRST = 8'h05;
  localparam logic [7:0] CALIBRATE = 8'h06;
  localparam logic [7:0] EMER_LAND = 8'h07;
  localparam logic [7:0] MTRS_OFF  = 8'h08;

  localparam logic [7:0] POS_ACK   = 8'hA5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    WAIT = 2'd3
  } state_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous first-word-fall-through FIFO holding queued {opcode, payload}
// frames; pointers carry one wrap bit to tell full from empty.
module cmd_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_wr_en;
  logic             w_rd_en;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_wr_en   = i_push && !o_full;
  assign w_rd_en   = i_pop && !o_empty;
  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, and leaving the array reset-free lets it map to RAM.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/comm_master_seq.sv
// Queued command master: serialises FIFO frames over a byte UART, then waits
// for a one-byte response with timeout and bounded retransmission.
module comm_master_seq
  import comm_pkg::*;
#(
  parameter int DATA_BYTES  = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 1048576,
  parameter int MAX_RETRY   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              cmd,
  input  logic [8*DATA_BYTES-1:0] data,
  input  logic                    snd_cmd,
  output logic                    cmd_full,
  output logic                    ovfl,
  output logic                    busy,
  output logic [7:0]              tx_data,
  output logic                    trmt,
  input  logic                    tx_done,
  input  logic [7:0]              rx_data,
  input  logic                    rx_rdy,
  output logic                    clr_rx_rdy,
  output logic                    frm_snt,
  output logic [7:0]              resp,
  output logic                    resp_vld,
  output logic                    resp_err
);

  localparam int FW = 8 + 8*DATA_BYTES;
  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int IW = $clog2(DATA_BYTES + 1);

  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BYTES);

  state_t          r_state;
  logic [FW-1:0]   r_frame;
  logic [IW-1:0]   r_idx;
  logic [TW-1:0]   r_tmo;
  logic [RW-1:0]   r_retry;
  logic [7:0]      r_tx_data;
  logic [7:0]      r_resp;
  logic            r_trmt;
  logic            r_frm_snt;
  logic            r_clr_rx_rdy;
  logic            r_resp_vld;
  logic            r_resp_err;
  logic            r_ovfl;

  logic [FW-1:0]   w_head;
  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic [IW-1:0]   w_nxt_idx;
  logic [7:0]      w_nxt_byte;
  logic            w_rx_fresh;

  cmd_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (snd_cmd),
    .i_wr_data ({cmd, data}),
    .i_pop     (w_pop),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  assign w_pop     = (r_state == LOAD);
  assign w_nxt_idx = r_idx + IW'(1);
  // A level rx_rdy already being cleared must not be counted a second time.
  assign w_rx_fresh = rx_rdy && !r_clr_rx_rdy;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_nxt_byte = '0;
    for (int k = 0; k <= DATA_BYTES; k++) begin
      if (w_nxt_idx == IW'(k)) w_nxt_byte = r_frame[8*(DATA_BYTES-k) +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_frame      <= '0;
      r_idx        <= '0;
      r_tmo        <= '0;
      r_retry      <= '0;
      r_tx_data    <= '0;
      r_resp       <= '0;
      r_trmt       <= 1'b0;
      r_frm_snt    <= 1'b0;
      r_clr_rx_rdy <= 1'b0;
      r_resp_vld   <= 1'b0;
      r_resp_err   <= 1'b0;
      r_ovfl       <= 1'b0;
    end else begin
      r_trmt       <= 1'b0;
      r_frm_snt    <= 1'b0;
      r_clr_rx_rdy <= 1'b0;
      r_resp_vld   <= 1'b0;
      r_resp_err   <= 1'b0;
      r_ovfl       <= snd_cmd && w_full;

      case (r_state)
        IDLE: begin
          if (w_rx_fresh) r_clr_rx_rdy <= 1'b1;
          if (!w_empty) r_state <= LOAD;
        end

        LOAD: begin
          if (w_rx_fresh) r_clr_rx_rdy <= 1'b1;
          r_frame   <= w_head;
          r_retry   <= '0;
          r_idx     <= '0;
          r_tx_data <= w_head[FW-1 -: 8];
          r_trmt    <= 1'b1;
          r_state   <= SEND;
        end

        SEND: begin
          if (w_rx_fresh) r_clr_rx_rdy <= 1'b1;
          if (tx_done && !r_trmt) begin
            if (r_idx == IDX_LAST) begin
              r_frm_snt <= 1'b1;
              r_tmo     <= '0;
              r_state   <= WAIT;
            end else begin
              r_idx     <= w_nxt_idx;
              r_tx_data <= w_nxt_byte;
              r_trmt    <= 1'b1;
            end
          end
        end

        WAIT: begin
          if (w_rx_fresh) begin
            r_resp       <= rx_data;
            r_clr_rx_rdy <= 1'b1;
            r_resp_vld   <= 1'b1;
            r_state      <= IDLE;
          end else if (r_tmo == TMO_LAST) begin
            if (r_retry < RETRY_MAX) begin
              r_retry   <= r_retry + RW'(1);
              r_idx     <= '0;
              r_tx_data <= r_frame[FW-1 -: 8];
              r_trmt    <= 1'b1;
              r_state   <= SEND;
            end else begin
              r_resp     <= '0;
              r_resp_err <= 1'b1;
              r_state    <= IDLE;
            end
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_full   = w_full;
  assign ovfl       = r_ovfl;
  assign busy       = (r_state != IDLE) || !w_empty;
  assign tx_data    = r_tx_data;
  assign trmt       = r_trmt;
  assign clr_rx_rdy = r_clr_rx_rdy;
  assign frm_snt    = r_frm_snt;
  assign resp       = r_resp;
  assign resp_vld   = r_resp_vld;
  assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_comm_master_seq.sv
// Directed scoreboard bench for comm_master_seq with behavioural UART TX/RX
// models; expected bytes and responses are queued at stimulus time.
module tb_comm_master_seq;
  import comm_pkg::*;

  localparam int DB        = 2;
  localparam int DEPTH     = 4;
  localparam int TMO       = 64;
  localparam int MR        = 2;
  localparam int TX_LAT    = 3;
  localparam int RSP_DLY   = 6;
  localparam int FRAME_CYC = (DB + 1) * (TX_LAT + 1);
  localparam int EV_TRMT   = 0;
  localparam int EV_VLD    = 1;
  localparam int EV_ERR    = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    cmd;
  logic [8*DB-1:0] data;
  logic          snd_cmd;
  logic          cmd_full, ovfl, busy, trmt, tx_done;
  logic          rx_rdy, clr_rx_rdy, frm_snt, resp_vld, resp_err;
  logic [7:0]    tx_data, rx_data, resp;

  int n_pass = 0;
  int n_total = 0;
  int n_trmt = 0, n_frm = 0, n_vld = 0, n_err = 0, n_clr = 0, n_ovfl = 0, cyc = 0;

  logic [7:0] exp_tx[$];
  logic [7:0] exp_rsp[$];
  int         frm_t[$];

  int         rsp_mode = 0;
  int         rsp_on_frm = 0;
  logic [7:0] rsp_byte = POS_ACK;
  int         stale_req = 0;

  logic [7:0]    ops[5];
  logic [8*DB-1:0] pls[5];

  always #5 clk = ~clk;

  comm_master_seq #(
    .DATA_BYTES  (DB),
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (TMO),
    .MAX_RETRY   (MR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd        (cmd),
    .data       (data),
    .snd_cmd    (snd_cmd),
    .cmd_full   (cmd_full),
    .ovfl       (ovfl),
    .busy       (busy),
    .tx_data    (tx_data),
    .trmt       (trmt),
    .tx_done    (tx_done),
    .rx_data    (rx_data),
    .rx_rdy     (rx_rdy),
    .clr_rx_rdy (clr_rx_rdy),
    .frm_snt    (frm_snt),
    .resp       (resp),
    .resp_vld   (resp_vld),
    .resp_err   (resp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int ev_count(input int sel);
    case (sel)
      EV_TRMT: return n_trmt;
      EV_VLD:  return n_vld;
      default: return n_err;
    endcase
  endfunction

  task automatic wait_evt(input int sel, input int target, input int budget, input string tag);
    int k;
    k = 0;
    while (ev_count(sel) < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(ev_count(sel) >= target), 32'd1);
  endtask

  task automatic add_exp(input logic [7:0] op, input logic [8*DB-1:0] pl);
    exp_tx.push_back(op);
    for (int k = DB - 1; k >= 0; k--) exp_tx.push_back(pl[8*k +: 8]);
  endtask

  task automatic push_frame(input logic [7:0] op, input logic [8*DB-1:0] pl);
    @(negedge clk);
    cmd = op;
    data = pl;
    snd_cmd = 1'b1;
    @(negedge clk);
    snd_cmd = 1'b0;
  endtask

  // Scoreboard: compare each DUT output event against queued expectations.
  always @(negedge clk) begin
    cyc++;
    if (trmt) begin
      n_trmt++;
      if (exp_tx.size() == 0) check("tx_unexpected", {24'd0, tx_data}, 32'hFFFF_FFFF);
      else check("tx_byte", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
    end
    if (resp_vld) begin
      n_vld++;
      check("vld_with_clr", {31'd0, clr_rx_rdy}, 32'd1);
      if (exp_rsp.size() == 0) check("resp_unexpected", {24'd0, resp}, 32'hFFFF_FFFF);
      else check("resp_val", {24'd0, resp}, {24'd0, exp_rsp.pop_front()});
    end
    if (resp_err) begin
      n_err++;
      check("resp_err_zero", {24'd0, resp}, 32'd0);
    end
    if (frm_snt) begin
      n_frm++;
      frm_t.push_back(cyc);
    end
    if (clr_rx_rdy) n_clr++;
    if (ovfl) n_ovfl++;
  end

  // UART transmitter: tx_done TX_LAT cycles after each trmt.
  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      while (trmt) begin
        repeat (TX_LAT) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
      end
    end
  end

  // UART receiver: level rx_rdy, cleared by clr_rx_rdy, optional reply per frame.
  initial begin
    int rx_frm;
    int dly;
    int stale_seen;
    rx_frm = 0;
    dly = 0;
    stale_seen = 0;
    rx_rdy = 1'b0;
    rx_data = 8'h00;
    forever begin
      @(negedge clk);
      if (clr_rx_rdy) rx_rdy = 1'b0;
      if (frm_snt) begin
        rx_frm++;
        if (rsp_mode == 2 || (rsp_mode == 1 && rx_frm == rsp_on_frm)) dly = RSP_DLY;
      end else if (dly > 0) begin
        dly--;
        if (dly == 0) begin
          rx_rdy = 1'b1;
          rx_data = rsp_byte;
        end
      end
      if (stale_req != stale_seen) begin
        stale_seen = stale_req;
        rx_rdy = 1'b1;
        rx_data = 8'h77;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base_frm, base_vld, base_err, base_ovfl, base_trmt, base_clr;
    ops = '{SET_YAW, SET_THRST, CALIBRATE, EMER_LAND, MTRS_OFF};
    pls = '{16'hA0B1, 16'hC2D3, 16'hE4F5, 16'h0607, 16'h8899};
    rst_n = 1'b0;
    cmd = 8'h00;
    data = '0;
    snd_cmd = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cmd_full", {31'd0, cmd_full}, 32'd0);
    check("rst_ovfl", {31'd0, ovfl}, 32'd0);
    check("rst_trmt", {31'd0, trmt}, 32'd0);
    check("rst_clr_rx_rdy", {31'd0, clr_rx_rdy}, 32'd0);
    check("rst_frm_snt", {31'd0, frm_snt}, 32'd0);
    check("rst_resp_vld", {31'd0, resp_vld}, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_resp", {24'd0, resp}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame with cycle-accurate start latency.
    rsp_mode = 1; rsp_on_frm = n_frm + 1; rsp_byte = POS_ACK;
    exp_rsp.push_back(POS_ACK);
    add_exp(SET_PTCH, 16'h0001);
    base_frm = n_frm; base_vld = n_vld;
    @(negedge clk);
    cmd = SET_PTCH; data = 16'h0001; snd_cmd = 1'b1;
    @(negedge clk);
    snd_cmd = 1'b0;
    check("c1_busy", {31'd0, busy}, 32'd1);
    check("c1_trmt", {31'd0, trmt}, 32'd0);
    @(negedge clk);
    check("c2_trmt", {31'd0, trmt}, 32'd0);
    @(negedge clk);
    check("c3_trmt", {31'd0, trmt}, 32'd1);
    wait_evt(EV_VLD, base_vld + 1, 200, "t1_vld_wait");
    check("t1_frm_cnt", 32'(n_frm - base_frm), 32'd1);
    repeat (2) @(negedge clk);
    check("t1_busy_idle", {31'd0, busy}, 32'd0);

    // Five pushes while frame 1 is in SEND: DEPTH accepted, the rest dropped.
    rsp_mode = 2; rsp_byte = POS_ACK;
    base_vld = n_vld; base_ovfl = n_ovfl; base_trmt = n_trmt;
    exp_rsp.push_back(POS_ACK);
    add_exp(SET_ROLL, 16'h1234);
    push_frame(SET_ROLL, 16'h1234);
    wait_evt(EV_TRMT, base_trmt + 1, 20, "t2_send_wait");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == DEPTH) check("t2_full_before_drop", {31'd0, cmd_full}, 32'd1);
      if (i < DEPTH) begin
        add_exp(ops[i], pls[i]);
        exp_rsp.push_back(POS_ACK);
      end
      cmd = ops[i]; data = pls[i]; snd_cmd = 1'b1;
    end
    @(negedge clk);
    snd_cmd = 1'b0;
    @(negedge clk);
    check("t2_ovfl_cnt", 32'(n_ovfl - base_ovfl), 32'd1);
    wait_evt(EV_VLD, base_vld + 1 + DEPTH, 600, "t2_all_vld");
    repeat (2) @(negedge clk);
    check("t2_busy_end", {31'd0, busy}, 32'd0);
    check("t2_tx_drained", 32'(exp_tx.size()), 32'd0);

    // No response: MR retries then resp_err.
    rsp_mode = 0;
    base_frm = n_frm; base_err = n_err; base_vld = n_vld;
    for (int a = 0; a <= MR; a++) add_exp(REQ_BATT, 16'h00FF);
    push_frame(REQ_BATT, 16'h00FF);
    wait_evt(EV_ERR, base_err + 1, (MR + 1) * (FRAME_CYC + TMO) + 100, "t3_err_wait");
    check("t3_frm_cnt", 32'(n_frm - base_frm), 32'(MR + 1));
    check("t3_vld_cnt", 32'(n_vld - base_vld), 32'd0);
    check("t3_resp_zero", {24'd0, resp}, 32'd0);
    check("t3_spacing_1", 32'(frm_t[base_frm+1] - frm_t[base_frm]), 32'(TMO + FRAME_CYC));
    check("t3_spacing_2", 32'(frm_t[base_frm+2] - frm_t[base_frm+1]), 32'(TMO + FRAME_CYC));

    // Response on the second attempt.
    rsp_mode = 1; rsp_on_frm = n_frm + 2; rsp_byte = 8'h3C;
    base_frm = n_frm; base_err = n_err; base_vld = n_vld;
    exp_rsp.push_back(8'h3C);
    add_exp(SET_YAW, 16'hBEEF);
    add_exp(SET_YAW, 16'hBEEF);
    push_frame(SET_YAW, 16'hBEEF);
    wait_evt(EV_VLD, base_vld + 1, 2 * (FRAME_CYC + TMO) + 100, "t4_vld_wait");
    repeat (TMO + FRAME_CYC + 10) @(negedge clk);
    check("t4_frm_cnt", 32'(n_frm - base_frm), 32'd2);
    check("t4_err_cnt", 32'(n_err - base_err), 32'd0);

    // Stale rx_rdy during SEND, then a genuine response.
    rsp_mode = 1; rsp_on_frm = n_frm + 1; rsp_byte = 8'h5A;
    base_trmt = n_trmt; base_clr = n_clr; base_vld = n_vld;
    exp_rsp.push_back(8'h5A);
    add_exp(SET_THRST, 16'h7F80);
    push_frame(SET_THRST, 16'h7F80);
    wait_evt(EV_TRMT, base_trmt + 1, 20, "t5_send_wait");
    stale_req++;
    repeat (4) @(negedge clk);
    check("t5_stale_clr", 32'(n_clr - base_clr), 32'd1);
    check("t5_resp_kept", {24'd0, resp}, 32'h3C);
    check("t5_no_vld", 32'(n_vld - base_vld), 32'd0);
    check("t5_rx_cleared", {31'd0, rx_rdy}, 32'd0);
    wait_evt(EV_VLD, base_vld + 1, 200, "t5_vld_wait");
    check("t5_clr_total", 32'(n_clr - base_clr), 32'd2);

    // Asynchronous reset while the second byte's trmt is high.
    rsp_mode = 0;
    base_trmt = n_trmt;
    add_exp(ops[0], pls[0]);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cmd = ops[i]; data = pls[i]; snd_cmd = 1'b1;
    end
    @(negedge clk);
    snd_cmd = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_trmt_pre", {31'd0, trmt}, 32'd1);
    check("t6_full_pre", {31'd0, cmd_full}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_trmt_async", {31'd0, trmt}, 32'd0);
    check("t6_busy_async", {31'd0, busy}, 32'd0);
    check("t6_full_async", {31'd0, cmd_full}, 32'd0);
    exp_tx.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("t6_busy_after", {31'd0, busy}, 32'd0);
    check("t6_trmt_cnt", 32'(n_trmt - base_trmt), 32'd2);

    // A clean frame after reset proves nothing stale remains queued.
    rsp_mode = 1; rsp_on_frm = n_frm + 1; rsp_byte = POS_ACK;
    base_vld = n_vld;
    exp_rsp.push_back(POS_ACK);
    add_exp(SET_ROLL, 16'h0203);
    push_frame(SET_ROLL, 16'h0203);
    wait_evt(EV_VLD, base_vld + 1, 200, "t7_vld_wait");
    repeat (5) @(negedge clk);
    check("end_tx_queue", 32'(exp_tx.size()), 32'd0);
    check("end_rsp_queue", 32'(exp_rsp.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
